// File: rtl/gw_pkg.sv
// Shared definitions for the sm510 program-ROM path.
// Holds the ROM geometry used by both the loader and the core, the loader
// state encoding, and a small checksum helper.
package gw_pkg;

    localparam int ROM_ADDR_W = 12;
    localparam int ROM_BYTES  = 4096;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PAD  = 3'd2,
        HOLD = 3'd3,
        RUN  = 3'd4
    } loader_state_t;

    // Running mod-256 sum of image bytes; wrap-around is intended.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/rom_dpram.sv
// Simple dual-port program memory: one write port, one enable-gated
// registered read port. Read-during-write to the same address returns the
// old contents. Only the output register is reset; the array is not.
// Ports:
//   i_clk        clock
//   i_reset      synchronous active-high reset of the read data register
//   i_wr_en      write strobe
//   i_wr_addr    write address
//   i_wr_data    write byte
//   i_rd_en      read enable (CPU clock enable)
//   i_rd_addr    read address
//   o_rd_data    registered read byte
module rom_dpram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [0:DEPTH-1];
    logic [7:0] r_rd_data;

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; samples the array before any same-cycle write lands.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= 8'h00;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rom_loader.sv
// Program-ROM loader in front of the sm510 core.
// Captures a host byte stream into program memory, zero-fills the unused
// tail, holds the CPU in reset for a fixed time once the image is complete,
// then releases it and serves enable-gated ROM fetches.
// Ports:
//   i_clk            system clock
//   i_reset          synchronous active-high reset
//   i_dl_active      host download window (rising edge starts a load)
//   i_dl_valid       i_dl_data holds a byte
//   i_dl_data        download byte
//   o_dl_ready       loader accepts a byte this cycle
//   i_clk_en         CPU clock enable
//   i_rom_addr       CPU fetch address
//   o_rom_data       registered fetch data
//   o_cpu_reset      CPU reset, high while the ROM is not valid
//   o_load_done      image loaded and CPU released
//   o_load_overflow  image was longer than the ROM (sticky until next load)
//   o_checksum       mod-256 sum of accepted bytes, padding excluded
module rom_loader
    import gw_pkg::*;
#(
    parameter int ROM_SIZE   = ROM_BYTES,
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int RESET_HOLD = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_dl_active,
    input  logic              i_dl_valid,
    input  logic [7:0]        i_dl_data,
    output logic              o_dl_ready,
    input  logic              i_clk_en,
    input  logic [ADDR_W-1:0] i_rom_addr,
    output logic [7:0]        o_rom_data,
    output logic              o_cpu_reset,
    output logic              o_load_done,
    output logic              o_load_overflow,
    output logic [7:0]        o_checksum
);

    localparam int                HOLD_W    = $clog2(RESET_HOLD + 1);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(ROM_SIZE);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W + 1)'(0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

    loader_state_t       r_state;
    loader_state_t       w_state_next;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     w_cnt_next;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_next;
    logic [7:0]          r_csum;
    logic [7:0]          w_csum_next;
    logic                r_ovf;
    logic                w_ovf_next;
    logic                r_active_prev;
    logic                r_dl_ready;
    logic                r_cpu_reset;
    logic                r_load_done;
    logic                w_rise;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [7:0]          w_wr_data;

    assign w_rise = i_dl_active & ~r_active_prev;

    // Next-state, counter, checksum and memory-write decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hold_next  = r_hold;
        w_csum_next  = r_csum;
        w_ovf_next   = r_ovf;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_cnt[ADDR_W-1:0];
        w_wr_data    = 8'h00;

        case (r_state)
            IDLE, RUN: begin
                if (w_rise) begin
                    w_state_next = LOAD;
                    w_cnt_next   = CNT_ZERO;
                    w_csum_next  = 8'h00;
                    w_ovf_next   = 1'b0;
                end else begin
                    w_state_next = r_state;
                end
            end
            LOAD: begin
                if (i_dl_valid) begin
                    // Once the ROM is full, keep draining the host but drop the data.
                    if (r_cnt == CNT_FULL) begin
                        w_ovf_next = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_wr_data   = i_dl_data;
                        w_csum_next = csum_add(r_csum, i_dl_data);
                        w_cnt_next  = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_wr_en = 1'b0;
                end
                // A byte arriving alongside the window closing is counted first.
                if (!i_dl_active) begin
                    w_hold_next = HOLD_ZERO;
                    if (w_cnt_next < CNT_FULL) begin
                        w_state_next = PAD;
                    end else begin
                        w_state_next = HOLD;
                    end
                end else begin
                    w_state_next = LOAD;
                end
            end
            PAD: begin
                w_wr_en    = 1'b1;
                w_wr_data  = 8'h00;
                w_cnt_next = r_cnt + CNT_ONE;
                if (w_cnt_next == CNT_FULL) begin
                    w_state_next = HOLD;
                    w_hold_next  = HOLD_ZERO;
                end else begin
                    w_state_next = PAD;
                end
            end
            HOLD: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_next = RUN;
                end else begin
                    w_hold_next = r_hold + HOLD_ONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_cnt         <= CNT_ZERO;
            r_hold        <= HOLD_ZERO;
            r_csum        <= 8'h00;
            r_ovf         <= 1'b0;
            // Track the live window level so a window already open during
            // reset is not mistaken for a new rising edge.
            r_active_prev <= i_dl_active;
            r_dl_ready    <= 1'b0;
            r_cpu_reset   <= 1'b1;
            r_load_done   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_hold        <= w_hold_next;
            r_csum        <= w_csum_next;
            r_ovf         <= w_ovf_next;
            r_active_prev <= i_dl_active;
            r_dl_ready    <= (w_state_next == LOAD);
            r_cpu_reset   <= (w_state_next != RUN);
            r_load_done   <= (w_state_next == RUN);
        end
    end

    rom_dpram #(
        .DEPTH (ROM_SIZE),
        .AW    (ADDR_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (i_clk_en),
        .i_rd_addr (i_rom_addr),
        .o_rd_data (o_rom_data)
    );

    assign o_dl_ready      = r_dl_ready;
    assign o_cpu_reset     = r_cpu_reset;
    assign o_load_done     = r_load_done;
    assign o_load_overflow = r_ovf;
    assign o_checksum      = r_csum;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: randomized images against a
// whole-image reference model (contents, checksum, overflow, release time).
module tb_rom_loader;

    localparam int ROM   = 4096;
    localparam int HOLDC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        dl_valid;
    logic [7:0]  dl_data;
    logic        dl_ready;
    logic        clk_en;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        cpu_reset;
    logic        load_done;
    logic        load_overflow;
    logic [7:0]  checksum;

    always #5 clk = ~clk;

    rom_loader dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_dl_active     (dl_active),
        .i_dl_valid      (dl_valid),
        .i_dl_data       (dl_data),
        .o_dl_ready      (dl_ready),
        .i_clk_en        (clk_en),
        .i_rom_addr      (rom_addr),
        .o_rom_data      (rom_data),
        .o_cpu_reset     (cpu_reset),
        .o_load_done     (load_done),
        .o_load_overflow (load_overflow),
        .o_checksum      (checksum)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the image as the ROM should hold it.
    logic [7:0] img[$];
    logic [7:0] ref_mem [0:ROM-1];
    logic [7:0] ref_csum;
    logic       ref_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-image view: first ROM bytes kept, rest zero, sum of kept bytes.
    function automatic void model_load();
        int n = img.size();
        ref_csum = 8'h00;
        for (int i = 0; i < ROM; i++) begin
            ref_mem[i] = (i < n) ? img[i] : 8'h00;
            if (i < n) ref_csum = ref_csum + img[i];
        end
        ref_ovf = (n > ROM);
    endfunction

    // Opens a window, streams img with random gaps, closes it and waits for release.
    task automatic load_image(input int gap_pct, input int idle_cycles);
        int n_rel;
        int kept;
        int exp_lat;
        model_load();
        kept    = (img.size() < ROM) ? img.size() : ROM;
        exp_lat = (ROM - kept) + HOLDC + 1;
        dl_active = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rise", dl_ready, 1);
        chk("cpu_reset_after_rise", cpu_reset, 1);
        chk("load_done_after_rise", load_done, 0);
        foreach (img[i]) begin
            while ($urandom_range(99) < gap_pct) begin
                dl_valid = 1'b0;
                @(posedge clk); #1;
            end
            dl_valid = 1'b1;
            dl_data  = img[i];
            @(posedge clk); #1;
        end
        dl_valid = 1'b0;
        repeat (idle_cycles) begin
            @(posedge clk); #1;
        end
        dl_active = 1'b0;
        n_rel = 0;
        for (int k = 1; k <= 6000; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("ready_after_fall", dl_ready, 0);
            if (!cpu_reset) begin
                n_rel = k;
                break;
            end
        end
        chk("release_latency", n_rel, exp_lat);
        chk("load_done", load_done, 1);
        chk("checksum", checksum, ref_csum);
        chk("overflow", load_overflow, ref_ovf);
    endtask

    // Reads every address, one enable tick each, against the model.
    task automatic verify_mem();
        clk_en = 1'b1;
        for (int a = 0; a < ROM; a++) begin
            rom_addr = a[11:0];
            @(posedge clk); #1;
            chk("mem_read", rom_data, ref_mem[a]);
        end
        clk_en = 1'b0;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        dl_active = 1'b0;
        dl_valid  = 1'b0;
        dl_data   = 8'h00;
        clk_en    = 1'b0;
        rom_addr  = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_dl_ready", dl_ready, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_overflow", load_overflow, 0);
        chk("rst_checksum", checksum, 8'h00);
        chk("rst_rom_data", rom_data, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: full image, no gaps, no padding.
        img.delete();
        for (int i = 0; i < ROM; i++) img.push_back(8'(i) ^ 8'h5A);
        load_image(0, 0);
        rom_addr = 12'h123;
        clk_en   = 1'b1;
        @(posedge clk); #1;
        chk("read_0x123", rom_data, 8'h79);
        clk_en   = 1'b0;
        rom_addr = 12'h000;
        @(posedge clk); #1;
        chk("read_gated", rom_data, 8'h79);
        verify_mem();

        // 2: short image, tail padded.
        img.delete();
        for (int i = 1; i <= 10; i++) img.push_back(8'(i));
        load_image(30, 0);
        chk("short_checksum", checksum, 8'h37);
        verify_mem();

        // 3: overflow, extra bytes dropped without wrap.
        img.delete();
        for (int i = 0; i < ROM + 4; i++) img.push_back(8'hFF);
        load_image(0, 0);
        chk("ovf_flag", load_overflow, 1);
        chk("ovf_checksum", checksum, 8'h00);
        rom_addr = 12'h000;
        clk_en   = 1'b1;
        @(posedge clk); #1;
        chk("ovf_mem0", rom_data, 8'hFF);
        clk_en = 1'b0;

        // 4: reload while running with a random image.
        img.delete();
        n = $urandom_range(4096, 1500);
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
        load_image(20, 0);
        verify_mem();

        // 5: reset at byte 500, trailing bytes must be ignored.
        dl_active = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 500; i++) begin
            dl_valid = 1'b1;
            dl_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_dl_ready", dl_ready, 0);
        chk("midrst_load_done", load_done, 0);
        chk("midrst_checksum", checksum, 8'h00);
        for (int i = 0; i < 20; i++) begin
            dl_data = 8'($urandom_range(255, 1));
            @(posedge clk); #1;
        end
        chk("midrst_ignored_ready", dl_ready, 0);
        chk("midrst_ignored_csum", checksum, 8'h00);
        dl_valid  = 1'b0;
        dl_active = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_still_held", cpu_reset, 1);
        img.delete();
        n = $urandom_range(3000, 200);
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
        load_image(10, 0);
        verify_mem();

        // 6: empty window, three clocks high.
        img.delete();
        load_image(0, 2);
        chk("empty_checksum", checksum, 8'h00);
        verify_mem();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Sits directly upstream of the sm510 core's program ROM port.
- Accepts a byte stream from the host download interface and writes it into an internal ROM_SIZE x 8 program memory.
- Zero-pads any short image, then releases the CPU from reset after a fixed hold.
- Serves rom_addr -> rom_data reads, registered on clk_en, so the core sees one-enable-tick read latency.

Parameters:
- ROM_SIZE, 4096, program memory depth in bytes; must be a power of two.
- ADDR_W, 12, address width; equals log2(ROM_SIZE).
- RESET_HOLD, 16, clk cycles that cpu_reset stays high after the image is complete.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- dl_active  in  1  host download window; rising edge starts a load
- dl_valid  in  1  dl_data holds a byte
- dl_data  in  8  download byte
- dl_ready  out  1  loader accepts the byte this cycle
- clk_en  in  1  CPU clock enable
- rom_addr  in  ADDR_W  CPU fetch address
- rom_data  out  8  registered fetch data
- cpu_reset  out  1  CPU reset, high while the ROM is not valid
- load_done  out  1  image loaded and CPU released
- load_overflow  out  1  image longer than ROM_SIZE
- checksum  out  8  mod-256 sum of accepted bytes, pad bytes excluded

Behaviour:
- Reset values:
  - state = IDLE, cpu_reset = 1, dl_ready = 0, rom_data = 0x00, load_done = 0, load_overflow = 0, checksum = 0x00.
  - byte counter cnt = 0 (ADDR_W+1 bits), hold counter = 0.
  - Memory contents are not cleared by reset.
- States and transitions:
  - IDLE: cpu_reset = 1. On dl_active rising edge (registered previous value) -> LOAD; clear cnt, checksum and load_overflow.
  - LOAD: dl_ready = 1.
    - On dl_valid & dl_ready: write mem[cnt] = dl_data, checksum += dl_data, cnt++.
    - When cnt == ROM_SIZE: dl_ready stays 1, bytes are consumed and dropped, load_overflow sets sticky, checksum is unchanged.
    - On dl_active falling: cnt < ROM_SIZE -> PAD; otherwise -> HOLD.
  - PAD: dl_ready = 0. Write mem[cnt] = 0x00 each cycle, cnt++. When cnt reaches ROM_SIZE -> HOLD.
  - HOLD: hold counter counts RESET_HOLD cycles, then -> RUN.
  - RUN: cpu_reset = 0, load_done = 1.
    - A new dl_active rising edge -> LOAD, asserting cpu_reset = 1 and load_done = 0 in the same edge's next cycle.
- Empty download (active pulse with no valid bytes): whole ROM padded with 0x00, checksum = 0x00, CPU released.
- Valid byte in the same cycle dl_active falls: byte is accepted, then the state advances.
- dl_valid while dl_active = 0 is ignored.
- Read port:
  - On clk_en: rom_data <= mem[rom_addr] in every state.
  - Data is meaningful only in RUN; the core sees it on the next enable tick.
  - A write and a read of the same address in the same cycle return the old data (read-first).
- reset mid-load: returns to IDLE, holds the CPU in reset, and ignores the remainder of the active window until the next rising edge.
- The memory must infer block RAM: one write port, one clk_en-gated read port.

Decomposition:
- Shared package gw_pkg holds:
  - typedef loader_state_t {IDLE, LOAD, PAD, HOLD, RUN};
  - ROM_ADDR_W = 12 and ROM_BYTES = 4096, shared with sm510.
- One natural sub-module, rom_dpram: simple dual-port RAM, write on clk, read registered with an enable.
- The FSM and counters stay in rom_loader.

Test Plan:
1. Full image: stream 4096 bytes of (addr ^ 0x5A) with no gaps, drop dl_active.
   - Required: no PAD; cpu_reset falls exactly 16 clks after HOLD entry.
   - Required: checksum equals the modelled mod-256 sum.
   - Required: read of addr 0x123 returns 0x79 one clk_en after presenting the address.
2. Short image: 10 bytes 0x01..0x0A, then dl_active low.
   - Required: PAD lasts 4086 cycles; mem[0x009] = 0x0A and mem[0x00A..0xFFF] = 0x00.
   - Required: checksum = 0x37; load_done = 1.
3. Overflow: 4100 bytes of 0xFF.
   - Required: load_overflow = 1 and mem[0] stays 0xFF (no wrap).
   - Required: checksum = (4096 * 0xFF) mod 256 = 0x00.
4. Reload while running:
   - Required: cpu_reset = 1 the cycle after the dl_active rising edge; load_done = 0.
   - Required: the new image replaces the old one; checksum is recomputed.
5. Reset mid-load at byte 500:
   - Required: state IDLE, cpu_reset = 1, dl_ready = 0.
   - Required: remaining valid bytes are ignored until the next rising edge of dl_active.
6. Empty window (dl_active high for 3 clks, no valid bytes):
   - Required: full pad, checksum = 0x00.
   - Required: CPU released after 4096 + 16 cycles.
